// File: rtl/stochastic_decoder_if.sv
// Handshake bundle for stochastic_decoder: the serial bit input, the count result and status.
// The master side drives the stream and consumes counts. The slave side is the decoder.
interface stochastic_decoder_if #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned IDX_W = 16
);

  logic             start;
  logic             bit_valid;
  logic             bit_in;
  logic             bit_ready;
  logic [CNT_W:0]   count_out;
  logic             count_valid;
  logic             count_ready;
  logic [IDX_W-1:0] win_idx;
  logic             busy;

  modport master (
    output start,
    output bit_valid,
    output bit_in,
    output count_ready,
    input  bit_ready,
    input  count_out,
    input  count_valid,
    input  win_idx,
    input  busy
  );

  modport slave (
    input  start,
    input  bit_valid,
    input  bit_in,
    input  count_ready,
    output bit_ready,
    output count_out,
    output count_valid,
    output win_idx,
    output busy
  );

endinterface

// File: rtl/stochastic_decoder.sv
// stochastic_decoder: counts the ones in each BIT_LENGTH-bit stochastic window.
// It delivers one registered count per window over a valid/ready handshake, along with a running window index.
// Optional macro STOCH_DEC_BIPOLAR_EN switches the result to bipolar form (2*ones - BIT_LENGTH, two's complement).
// When the macro is undefined, the result is the unipolar ones-count, zero-extended.
module stochastic_decoder #(
  parameter int unsigned BIT_LENGTH = 128,
  parameter int unsigned CNT_W      = $clog2(BIT_LENGTH + 1),
  parameter int unsigned IDX_W      = 16
) (
  input logic                clk,
  input logic                rst,
  stochastic_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;

  logic [CNT_W-1:0] ones_q, ones_d;
  logic [CNT_W-1:0] bits_q, bits_d;
  logic [CNT_W:0]   count_q, count_d;
  logic             count_valid_q, count_valid_d;
  logic [IDX_W-1:0] win_idx_q, win_idx_d;
  logic             bit_ready_q, bit_ready_d;
  logic             busy_q, busy_d;

  logic             accept_c;
  logic             last_c;
  logic             handshake_c;
  logic [CNT_W-1:0] ones_total_c;
  logic [CNT_W:0]   result_c;

  // Decode the events the FSM and the datapath act on this cycle
  always_comb begin
    accept_c     = bus.bit_valid && bit_ready_q;
    last_c       = accept_c && (bits_q == CNT_W'(BIT_LENGTH - 1));
    handshake_c  = count_valid_q && bus.count_ready;
    ones_total_c = ones_q + CNT_W'(bus.bit_in);
`ifdef STOCH_DEC_BIPOLAR_EN
    result_c     = {ones_total_c, 1'b0} - (CNT_W + 1)'(BIT_LENGTH);
`else
    result_c     = {1'b0, ones_total_c};
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start only in IDLE, the last bit ends ACCUM, and the handshake ends DONE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (last_c) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (handshake_c) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values. The status flags follow the next state, so they are registered in step with it.
  always_comb begin
    ones_d        = ones_q;
    bits_d        = bits_q;
    count_d       = count_q;
    count_valid_d = count_valid_q;
    win_idx_d     = win_idx_q;
    bit_ready_d   = (state_d == S_ACCUM);
    busy_d        = (state_d != S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          ones_d = '0;
          bits_d = '0;
        end
      end
      S_ACCUM: begin
        if (accept_c) begin
          bits_d = bits_q + CNT_W'(1);
          ones_d = ones_total_c;
        end
        if (last_c) begin
          count_d       = result_c;
          count_valid_d = 1'b1;
        end
      end
      S_DONE: begin
        if (handshake_c) begin
          count_valid_d = 1'b0;
          win_idx_d     = win_idx_q + IDX_W'(1);
        end
      end
      default: begin
        count_valid_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers. Reset discards any partial or pending window.
  always_ff @(posedge clk) begin
    if (rst) begin
      ones_q        <= '0;
      bits_q        <= '0;
      count_q       <= '0;
      count_valid_q <= 1'b0;
      win_idx_q     <= '0;
      bit_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      ones_q        <= ones_d;
      bits_q        <= bits_d;
      count_q       <= count_d;
      count_valid_q <= count_valid_d;
      win_idx_q     <= win_idx_d;
      bit_ready_q   <= bit_ready_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.bit_ready   = bit_ready_q;
  assign bus.count_out   = count_q;
  assign bus.count_valid = count_valid_q;
  assign bus.win_idx     = win_idx_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_stochastic_decoder.sv
// Scoreboard bench for stochastic_decoder. Expected counts are queued when a window is issued.
// A forked monitor pops an entry and compares it on every count handshake.
module tb_stochastic_decoder;

  localparam int unsigned BL   = 128;
  localparam int unsigned CW   = 8;
  localparam int unsigned IW   = 16;
  localparam int unsigned NWIN = 500;

  typedef struct packed {
    logic [CW:0]   cnt;
    logic [IW-1:0] idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  stochastic_decoder_if #(.CNT_W(CW), .IDX_W(IW)) dif ();

  stochastic_decoder #(.BIT_LENGTH(BL), .CNT_W(CW), .IDX_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  always #5 clk = ~clk;

  int   checks  = 0;
  int   errors  = 0;
  int   exp_idx = 0;
  exp_t sb[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [CW:0] exp_count(input int k);
`ifdef STOCH_DEC_BIPOLAR_EN
    return (CW + 1)'(2 * k - int'(BL));
`else
    return (CW + 1)'(k);
`endif
  endfunction

  // mode 0: k ones scattered through the window (67 is odd, so i*67 mod 128 is a permutation); mode 1: 1010...
  function automatic logic pat_bit(input int mode, input int k, input int i);
    if (mode == 1) return (i % 2) == 0;
    return ((i * 67) % int'(BL)) < k;
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (dif.count_valid === 1'b1 && dif.count_ready === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got handshake with count %0h expected none", dif.count_out);
        end else begin
          e = sb.pop_front();
          check("count_out", 32'(dif.count_out), 32'(e.cnt));
          check("win_idx", 32'(dif.win_idx), 32'(e.idx));
        end
      end
    end
  endtask

  task automatic send_window(input int mode, input int k, input bit stall);
    exp_t e;
    int   i;
    int   c;
    e.cnt = exp_count(k);
    e.idx = IW'(exp_idx);
    sb.push_back(e);
    dif.start = 1'b1;
    tick();
    dif.start = 1'b0;
    i = 0;
    c = 0;
    while (i < int'(BL)) begin
      if (stall && (c % 3 == 2)) begin
        dif.bit_valid = 1'b0;
        dif.bit_in    = 1'b1;
      end else begin
        dif.bit_valid = 1'b1;
        dif.bit_in    = pat_bit(mode, k, i);
      end
      if (i == int'(BL) - 1 && dif.bit_valid) check("no_early_valid", 32'(dif.count_valid), 32'd0);
      tick();
      if (dif.bit_valid) i++;
      c++;
    end
    dif.bit_valid = 1'b0;
    check("valid_latency", 32'(dif.count_valid), 32'd1);
  endtask

  task automatic handshake();
    dif.count_ready = 1'b1;
    tick();
    dif.count_ready = 1'b0;
    exp_idx++;
    check("idx_after_hs", 32'(dif.win_idx), 32'(IW'(exp_idx)));
    check("valid_cleared", 32'(dif.count_valid), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bit_ready"}, 32'(dif.bit_ready), 32'd0);
    check({tag, "_count_out"}, 32'(dif.count_out), 32'd0);
    check({tag, "_count_valid"}, 32'(dif.count_valid), 32'd0);
    check({tag, "_win_idx"}, 32'(dif.win_idx), 32'd0);
    check({tag, "_busy"}, 32'(dif.busy), 32'd0);
  endtask

  initial begin
    fork
      monitor();
    join_none

    rst             = 1'b1;
    dif.start       = 1'b0;
    dif.bit_valid   = 1'b0;
    dif.bit_in      = 1'b0;
    dif.count_ready = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // all ones, all zeros, alternating with a stall every third cycle
    send_window(0, 128, 1'b0);
    handshake();
    send_window(0, 0, 1'b0);
    handshake();
    send_window(1, 64, 1'b1);
    handshake();

    // back-pressure: the result holds while extra bits and starts are ignored
    send_window(0, 77, 1'b0);
    for (int c = 0; c < 10; c++) begin
      dif.bit_valid = 1'b1;
      dif.bit_in    = 1'b1;
      dif.start     = (c % 3 == 0);
      tick();
      check("hold_count", 32'(dif.count_out), 32'(exp_count(77)));
      check("hold_valid", 32'(dif.count_valid), 32'd1);
      check("hold_bit_ready", 32'(dif.bit_ready), 32'd0);
    end
    dif.bit_valid = 1'b0;
    dif.start     = 1'b1;
    handshake();
    dif.start = 1'b0;
    check("idle_after_hs", 32'(dif.busy), 32'd0);
    tick();
    check("start_on_hs_ignored", 32'(dif.busy), 32'd0);

    // reset in the middle of a window
    dif.start = 1'b1;
    tick();
    dif.start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      dif.bit_valid = 1'b1;
      dif.bit_in    = 1'b1;
      tick();
    end
    dif.bit_valid = 1'b0;
    rst = 1'b1;
    tick();
    check_all_zero("midrst");
    rst     = 1'b0;
    exp_idx = 0;
    tick();
    send_window(0, 128, 1'b0);
    handshake();

    // long run of consecutive windows with known ones-counts
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    exp_idx = 0;
    tick();
    for (int w = 0; w < int'(NWIN); w++) begin
      send_window(0, (w * 37 + 5) % 129, (w % 7) == 0);
      handshake();
    end
    check("final_win_idx", 32'(dif.win_idx), 32'(NWIN));
    tick();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
